// File: rtl/avgr_param.sv
// avgr_param: averages blocks of 2**LOG2_N FIFO samples into the result RAM; last fifo_rd to ram_wr_n low is 3 cycles.
// Reads stall while fifo_empty is high; define AVGR_ROUND_EN for saturating round-half-up instead of truncation.
module avgr_param #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              rd_fifo,
  input  logic              dis_rd_fifo,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              avging,
  output logic              avg_done,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] result
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N:0] N_CNT = {1'b1, {LOG2_N{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DIVD, OUTP} state_t;

  state_t            state;
  logic              run_en;
  logic              rd_q;
  logic [ACC_W-1:0]  acc;
  logic [LOG2_N:0]   issued;
  logic [LOG2_N:0]   accum_cnt;
  logic [DATA_W-1:0] avg_val;

  assign fifo_rd  = (state == ACCUM) && (issued < N_CNT) && !fifo_empty;
  assign avging   = (state == ACCUM);
  assign avg_done = (state == OUTP);
  assign ram_wr_n = (state != OUTP);

`ifdef AVGR_ROUND_EN
  // (acc + 2**(LOG2_N-1)) >> LOG2_N equals (acc >> LOG2_N) plus the bit just below the cut.
  logic [DATA_W:0] rounded;
  assign rounded = {1'b0, acc[ACC_W-1:LOG2_N]} + {{DATA_W{1'b0}}, acc[LOG2_N-1]};
  assign avg_val = rounded[DATA_W] ? {DATA_W{1'b1}} : rounded[DATA_W-1:0];
`else
  assign avg_val = acc[ACC_W-1:LOG2_N];
`endif

  // Clear wins when both control pulses land in the same cycle.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      run_en <= 1'b0;
    end else if (dis_rd_fifo) begin
      run_en <= 1'b0;
    end else if (rd_fifo) begin
      run_en <= 1'b1;
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_q      <= 1'b0;
      acc       <= '0;
      issued    <= '0;
      accum_cnt <= '0;
      ram_addr  <= '0;
      result    <= '0;
    end else begin
      rd_q <= fifo_rd;
      case (state)
        IDLE: begin
          acc       <= '0;
          issued    <= '0;
          accum_cnt <= '0;
          if (run_en) state <= ACCUM;
        end
        ACCUM: begin
          if (fifo_rd) issued <= issued + 1'b1;
          // Data returned by the FIFO lands one cycle after its read strobe.
          if (rd_q) begin
            acc       <= acc + {{LOG2_N{1'b0}}, fifo_data};
            accum_cnt <= accum_cnt + 1'b1;
            if (accum_cnt + 1'b1 == N_CNT) state <= DIVD;
          end
        end
        DIVD: begin
          result <= avg_val;
          state  <= OUTP;
        end
        OUTP: begin
          ram_addr <= ram_addr + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avgr_param.sv
// Bench for avgr_param: FIFO model, write monitor and an arithmetic reference for each block average.
module tb_avgr_param;

  localparam int DW  = 8;
  localparam int L2N = 2;
  localparam int AW  = 2;
  localparam int N   = 1 << L2N;

  logic          clk_2 = 1'b0;
  logic          reset_n;
  logic          rd_fifo;
  logic          dis_rd_fifo;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd;
  logic [DW-1:0] fifo_data = '0;
  logic          avging;
  logic          avg_done;
  logic          ram_wr_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] result;

  always #5 clk_2 = ~clk_2;

  avgr_param #(.DATA_W(DW), .LOG2_N(L2N), .ADDR_W(AW)) dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .rd_fifo    (rd_fifo),
    .dis_rd_fifo(dis_rd_fifo),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_data  (fifo_data),
    .avging     (avging),
    .avg_done   (avg_done),
    .ram_wr_n   (ram_wr_n),
    .ram_addr   (ram_addr),
    .result     (result)
  );

  int errors = 0;
  int checks = 0;

  // Show-ahead-free FIFO: data appears the cycle after a read strobe.
  int fq[$];
  always @(posedge clk_2) begin
    if (fifo_rd === 1'b1 && fq.size() > 0) fifo_data <= DW'(fq.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  int cyc = 0, rd_cnt = 0, last_rd = 0, done_bad = 0;
  int w_addr[$], w_res[$], w_done[$], w_cyc[$], w_lat[$];
  always @(negedge clk_2) begin
    cyc++;
    if (fifo_rd === 1'b1) begin
      rd_cnt++;
      last_rd = cyc;
    end
    if (ram_wr_n === 1'b0) begin
      w_addr.push_back(int'(ram_addr));
      w_res.push_back(int'(result));
      w_done.push_back(int'(avg_done));
      w_cyc.push_back(cyc);
      w_lat.push_back(cyc - last_rd);
    end
    if (reset_n === 1'b1 && avg_done !== !ram_wr_n) done_bad++;
  end

  int e_addr[$], e_res[$];
  int model_addr = 0;
  int wi = 0;

  function automatic int model_avg(input int sum);
`ifdef AVGR_ROUND_EN
    int r = (sum + N / 2) / N;
    return (r > (1 << DW) - 1) ? (1 << DW) - 1 : r;
`else
    return sum / N;
`endif
  endfunction

  task automatic expect_block(input int s[N]);
    int sum = 0;
    for (int i = 0; i < N; i++) sum += s[i];
    e_res.push_back(model_avg(sum));
    e_addr.push_back(model_addr);
    model_addr = (model_addr + 1) % (1 << AW);
  endtask

  task automatic feed(input int s[N], input int from, input int to);
    for (int i = from; i < to; i++) fq.push_back(s[i]);
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_wr(input int n, input int budget);
    int k = 0;
    while (w_addr.size() < n && k < budget) begin tick(); k++; end
    chk("wr_timeout", int'(w_addr.size() >= n), 1);
  endtask

  task automatic wait_rd(input int n, input int budget);
    int k = 0;
    while (rd_cnt < n && k < budget) begin tick(); k++; end
    chk("rd_timeout", int'(rd_cnt >= n), 1);
  endtask

  task automatic wait_avging(input int budget);
    int k = 0;
    while (avging !== 1'b1 && k < budget) begin tick(); k++; end
    chk("avging_timeout", avging, 1);
  endtask

  task automatic pulse_run();
    rd_fifo = 1'b1; tick(); rd_fifo = 1'b0;
  endtask

  task automatic pulse_dis();
    dis_rd_fifo = 1'b1; tick(); dis_rd_fifo = 1'b0;
  endtask

  task automatic chk_write(input string tag);
    chk({tag, "_present"}, int'(w_addr.size() > wi && e_addr.size() > wi), 1);
    if (w_addr.size() > wi && e_addr.size() > wi) begin
      chk({tag, "_addr"}, w_addr[wi], e_addr[wi]);
      chk({tag, "_result"}, w_res[wi], e_res[wi]);
      chk({tag, "_done"}, w_done[wi], 1);
      chk({tag, "_latency"}, w_lat[wi], 3);
    end
    wi++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fifo_rd"}, fifo_rd, 0);
    chk({tag, "_avging"}, avging, 0);
    chk({tag, "_avg_done"}, avg_done, 0);
    chk({tag, "_ram_wr_n"}, ram_wr_n, 1);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_result"}, result, 0);
  endtask

  initial begin
    int s[N];
    int base, nw;

    reset_n = 1'b0; rd_fifo = 1'b0; dis_rd_fifo = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    tick();

    // Basic average, then run enable dropped so the block stands alone.
    s = '{10, 20, 30, 40};
    expect_block(s); feed(s, 0, N);
    pulse_run(); wait_avging(20); pulse_dis();
    wait_wr(1, 40);
    chk_write("basic");
    repeat (3) tick();
    chk("basic_addr_next", ram_addr, 1);
    chk("basic_idle", avging, 0);
    chk("basic_result_held", result, 25);
    chk("basic_rd_total", rd_cnt, N);

    s = '{255, 255, 255, 255};
    expect_block(s); feed(s, 0, N);
    pulse_run(); wait_avging(20); pulse_dis();
    wait_wr(2, 40);
    chk_write("fullscale");

    s = '{1, 2, 2, 2};
    expect_block(s); feed(s, 0, N);
    pulse_run(); wait_avging(20); pulse_dis();
    wait_wr(3, 40);
    chk_write("round");

    // Two random blocks back to back; the second wraps the address.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 255));
      expect_block(s); feed(s, 0, N);
    end
    pulse_run();
    wait_wr(4, 40); wait_avging(20); pulse_dis();
    wait_wr(5, 40);
    chk_write("rand0");
    chk_write("rand1");

    // Stall after two reads with the FIFO drained.
    base = rd_cnt;
    for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 255));
    expect_block(s); feed(s, 0, 2);
    pulse_run();
    wait_rd(base + 2, 30);
    for (int i = 0; i < 5; i++) begin
      chk("stall_fifo_rd", fifo_rd, 0);
      chk("stall_avging", avging, 1);
      tick();
    end
    feed(s, 2, N); pulse_dis();
    wait_wr(6, 40);
    chk_write("stall");
    repeat (3) tick();
    chk("stall_rd_total", rd_cnt - base, N);

    // Reset after three accumulated samples discards the block.
    base = rd_cnt; nw = w_addr.size();
    for (int i = 0; i < 3; i++) fq.push_back(int'($urandom_range(0, 255)));
    pulse_run();
    wait_rd(base + 3, 30);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    chk("midrst_no_write", w_addr.size(), nw);
    model_addr = 0;
    fq.delete();
    tick();
    reset_n = 1'b1;
    tick();

    // Five continuous blocks, dis_rd_fifo during the fifth.
    nw = w_addr.size();
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 255));
      expect_block(s); feed(s, 0, N);
    end
    pulse_run();
    wait_wr(nw + 4, 100); wait_avging(20); pulse_dis();
    wait_wr(nw + 5, 40);
    for (int b = 0; b < 5; b++) chk_write("cont");
    for (int b = 1; b < 5; b++)
      if (w_cyc.size() > nw + b) chk("cont_period", w_cyc[nw + b] - w_cyc[nw + b - 1], N + 4);
    for (int i = 0; i < N; i++) fq.push_back(int'($urandom_range(0, 255)));
    base = rd_cnt;
    repeat (15) tick();
    chk("dis_no_reads", rd_cnt, base);
    chk("dis_no_writes", w_addr.size(), nw + 5);
    chk("dis_idle", avging, 0);

    // Simultaneous set and clear leaves the block idle.
    rd_fifo = 1'b1; dis_rd_fifo = 1'b1;
    tick();
    rd_fifo = 1'b0; dis_rd_fifo = 1'b0;
    repeat (12) tick();
    chk("both_no_reads", rd_cnt, base);
    chk("both_idle", avging, 0);
    chk("both_no_writes", w_addr.size(), nw + 5);
    chk("done_tracks_wr", done_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
